// File: rtl/mealy_stream_arbiter.sv
// Round-robin arbiter sharing one serial Mealy sequence detector among NUM_REQ bit-stream requesters.
// Define MEALY_ARB_TIMEOUT_EN to abort a burst whose owner stays silent for TIMEOUT cycles.
module mealy_stream_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int CNT_W    = 8,
  parameter int MAX_BITS = 200,
  parameter int TIMEOUT  = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] bit_valid,
  input  logic [NUM_REQ-1:0] bit_data,
  input  logic [NUM_REQ-1:0] bit_last,
  output logic [NUM_REQ-1:0] gnt,
  output logic               det_clr,
  output logic               det_en,
  output logic               det_w,
  input  logic               det_z,
  output logic               done,
  output logic [ID_W-1:0]    res_id,
  output logic [CNT_W-1:0]   res_hits,
  output logic               res_abort
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_RUN    = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic [CNT_W-1:0]   res_hits_q, res_hits_d;
  logic               res_abort_q, res_abort_d;

  logic [ID_W-1:0]    cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;
  logic [ID_W-1:0]    win_idx;
  logic               win_found;
  logic               own_valid, own_data, own_last, own_req;
  logic               norm_end, timeout;

  // Candidate gi is the requester gi+1 places after the last winner, wrapping modulo NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      localparam int OFS = gi + 1;
      assign cand_idx[gi] = (int'(rr_q) + OFS >= NUM_REQ) ? ID_W'(int'(rr_q) + OFS - NUM_REQ)
                                                         : ID_W'(int'(rr_q) + OFS);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  // gnt_q is one-hot on the owner throughout RUN, so it doubles as the lane select.
  assign own_valid = |(bit_valid & gnt_q);
  assign own_data  = |(bit_data & gnt_q);
  assign own_last  = |(bit_last & gnt_q);
  assign own_req   = |(req & gnt_q);

  assign det_en  = (state_q == ST_RUN) && own_valid;
  assign det_w   = (state_q == ST_RUN) && own_data;
  assign det_clr = (state_q == ST_ARB);
  assign done    = (state_q == ST_REPORT);

`ifdef MEALY_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = '0;
    if (state_q == ST_RUN && !det_en) idle_d = idle_q + 1'b1;
  end

  // Ending the burst here puts REPORT exactly TIMEOUT cycles after the last owner bit.
  assign timeout = (state_q == ST_RUN) && !det_en && (idle_q == IDLE_W'(TIMEOUT - 2));

  always_ff @(posedge Clock) begin
    if (Reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign norm_end = det_en && (own_last || ((bit_q + 1'b1) == CNT_W'(MAX_BITS)));

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    hit_d       = hit_q;
    bit_d       = bit_q;
    res_id_d    = res_id_q;
    res_hits_d  = res_hits_q;
    res_abort_d = res_abort_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (|req) state_d = ST_ARB;
      end
      ST_ARB: begin
        hit_d = '0;
        bit_d = '0;
        if (win_found) begin
          gnt_d   = NUM_REQ'(1) << win_idx;
          rr_d    = win_idx;
          state_d = ST_RUN;
        end else begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (det_en) begin
          bit_d = bit_q + 1'b1;
          if (det_z && hit_q != '1) hit_d = hit_q + 1'b1;
        end
        // A last bit arriving with the req drop still counts as a normal end.
        if (norm_end || !own_req || timeout) begin
          state_d     = ST_REPORT;
          gnt_d       = '0;
          res_id_d    = rr_q;
          res_hits_d  = hit_d;
          res_abort_d = !norm_end;
        end
      end
      ST_REPORT: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rr_q        <= ID_W'(NUM_REQ - 1);
      hit_q       <= '0;
      bit_q       <= '0;
      res_id_q    <= '0;
      res_hits_q  <= '0;
      res_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      hit_q       <= hit_d;
      bit_q       <= bit_d;
      res_id_q    <= res_id_d;
      res_hits_q  <= res_hits_d;
      res_abort_q <= res_abort_d;
    end
  end

  assign gnt       = gnt_q;
  assign res_id    = res_id_q;
  assign res_hits  = res_hits_q;
  assign res_abort = res_abort_q;

endmodule

// File: tb/tb_mealy_stream_arbiter.sv
// Scoreboard bench for mealy_stream_arbiter: directed bursts plus randomized traffic against a
// burst-level reference model ("01" detector hits, round-robin winner selection).
module tb_mealy_stream_arbiter;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int CW   = 8;
  localparam int MAXB = 8;
  localparam int TMO  = 16;

  logic           Clock = 1'b0;
  logic           Reset;
  logic [N-1:0]   req, bit_valid, bit_data, bit_last, gnt;
  logic           det_clr, det_en, det_w, det_z, done, res_abort;
  logic [IDW-1:0] res_id;
  logic [CW-1:0]  res_hits;

  int checks   = 0;
  int failures = 0;
  int m_rr;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [CW-1:0]  hits;
    logic           abort;
  } res_t;
  res_t exp_q[$];
  res_t mon_e;

  always #5 Clock = ~Clock;

  mealy_stream_arbiter #(
    .NUM_REQ(N), .ID_W(IDW), .CNT_W(CW), .MAX_BITS(MAXB), .TIMEOUT(TMO)
  ) dut (
    .Clock(Clock), .Reset(Reset), .req(req), .bit_valid(bit_valid), .bit_data(bit_data),
    .bit_last(bit_last), .gnt(gnt), .det_clr(det_clr), .det_en(det_en), .det_w(det_w),
    .det_z(det_z), .done(done), .res_id(res_id), .res_hits(res_hits), .res_abort(res_abort)
  );

  // External "01" Mealy detector: flags a 1 that directly follows a 0.
  logic zero_seen;
  always @(posedge Clock) begin
    if (Reset || det_clr) zero_seen <= 1'b0;
    else if (det_en)      zero_seen <= ~det_w;
  end
  assign det_z = zero_seen & det_w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req_v);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks lane steering during RUN.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("res_id", 32'(res_id), 32'(mon_e.id));
          chk("res_hits", 32'(res_hits), 32'(mon_e.hits));
          chk("res_abort", 32'(res_abort), 32'(mon_e.abort));
          $display("burst id=%0d hits=%0d abort=%0d (exp %0d/%0d/%0d)",
                   res_id, res_hits, res_abort, mon_e.id, mon_e.hits, mon_e.abort);
        end
        chk("gnt_in_report", 32'(gnt), 32'd0);
      end
      if (gnt != '0) begin
        chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
        chk("det_en", 32'(det_en), 32'(|(bit_valid & gnt)));
        if (det_en) chk("det_w", 32'(det_w), 32'(|(bit_data & gnt)));
      end else begin
        chk("det_en_idle", 32'(det_en), 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic noise();
    bit_valid = N'($urandom);
    bit_data  = N'($urandom);
    bit_last  = N'($urandom);
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic int count_hits(input logic [15:0] pat, input int cnt);
    int h = 0;
    for (int i = 1; i < cnt; i++) if (!pat[i-1] && pat[i]) h++;
    return h;
  endfunction

  // Steps until gnt appears; on return the current cycle is the first RUN cycle.
  task automatic wait_grant(input int w, output bit got);
    logic last_clr;
    last_clr = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      noise();
      last_clr = det_clr;
      step();
      if (gnt != '0) got = 1'b1;
    end
    chk("gnt", 32'(gnt), 32'(1 << w));
    if (got) chk("det_clr_before_grant", 32'(last_clr), 32'd1);
  endtask

  task automatic drive_bit(input int w, input logic b, input logic lst, input bit gaps);
    if (gaps) begin
      for (int g = 0; g < 3 && $urandom_range(3) == 0; g++) begin
        noise();
        bit_valid[w] = 1'b0;
        step();
      end
    end
    noise();
    bit_valid[w] = 1'b1;
    bit_data[w]  = b;
    bit_last[w]  = lst;
    step();
  endtask

  // mode 0: last on bit nbits; mode 1: MAXB bits without last; mode 2: nbits then req drop.
  task automatic run_burst(input int mode, input int nbits, input logic [15:0] pat,
                           input bit keep_req, input bit gaps);
    int w, cnt;
    bit got;
    res_t e;
    w = pick(req);
    cnt = (mode == 1) ? MAXB : nbits;
    e.id = IDW'(w);
    e.hits = CW'(count_hits(pat, cnt));
    e.abort = (mode == 2);
    exp_q.push_back(e);
    m_rr = w;
    wait_grant(w, got);
    if (!got) return;
    for (int i = 0; i < cnt; i++) drive_bit(w, pat[i], (mode == 0 && i == cnt - 1), gaps);
    if (mode == 2) begin
      noise();
      bit_valid[w] = 1'b0;
      req[w] = 1'b0;
      step();
    end
    chk("done_timing", 32'(done), 32'd1);
    if (!keep_req) req[w] = 1'b0;
  endtask

  // Owner sends "01" then goes silent.
  task automatic stall_burst();
    int w;
    bit got;
    res_t e;
    w = pick(req);
    e.id = IDW'(w);
    e.hits = 1;
    e.abort = 1'b1;
    exp_q.push_back(e);
    m_rr = w;
    wait_grant(w, got);
    if (!got) return;
    drive_bit(w, 1'b0, 1'b0, 1'b0);
    drive_bit(w, 1'b1, 1'b0, 1'b0);
`ifdef MEALY_ARB_TIMEOUT_EN
    for (int k = 1; k < TMO; k++) begin
      if (done) break;
      noise();
      bit_valid[w] = 1'b0;
      step();
    end
    chk("timeout_done", 32'(done), 32'd1);
    req[w] = 1'b0;
`else
    for (int k = 1; k < 100; k++) begin
      noise();
      bit_valid[w] = 1'b0;
      step();
    end
    chk("stall_gnt_held", 32'(gnt), 32'(1 << w));
    noise();
    bit_valid[w] = 1'b0;
    req[w] = 1'b0;
    step();
    chk("stall_abort_done", 32'(done), 32'd1);
`endif
  endtask

  initial begin
    int w, mode, nb;
    bit got;
    Reset = 1'b1;
    req = '0;
    bit_valid = '0;
    bit_data = '0;
    bit_last = '0;
    m_rr = N - 1;
    repeat (3) step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_det_clr", 32'(det_clr), 32'd0);
    chk("rst_det_en", 32'(det_en), 32'd0);
    chk("rst_det_w", 32'(det_w), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'({res_id, res_hits, res_abort}), 32'd0);
    Reset = 1'b0;

    // Single requester, stream 0,1,1,0,1 -> two hits.
    req = 4'b0001;
    run_burst(0, 5, 16'h0016, 1'b0, 1'b0);

    // All requesting, 1-bit bursts: rotation with wrap from 3 to 0.
    req = 4'b1111;
    for (int b = 0; b < 5; b++) run_burst(0, 1, 16'($urandom), 1'b1, 1'b0);

    // Owner 2 aborts after 0,1,1.
    req = 4'b0100;
    run_burst(2, 3, 16'h0006, 1'b0, 1'b0);

    // Bit limit end, then last bit coinciding with the limit.
    req = 4'b0010;
    run_burst(1, MAXB, 16'($urandom), 1'b0, 1'b1);
    req = 4'b1000;
    run_burst(0, MAXB, 16'($urandom), 1'b0, 1'b0);

    // Reset in the middle of a burst.
    req = 4'b1010;
    w = pick(req);
    wait_grant(w, got);
    for (int i = 0; i < 3; i++) drive_bit(w, 1'($urandom), 1'b0, 1'b0);
    noise();
    bit_valid[w] = 1'b1;
    bit_last[w] = 1'b0;
    Reset = 1'b1;
    step();
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_det_en", 32'(det_en), 32'd0);
    chk("midrst_res_hits", 32'(res_hits), 32'd0);
    Reset = 1'b0;
    m_rr = N - 1;
    req = 4'b1111;
    run_burst(0, 3, 16'($urandom), 1'b0, 1'b0);

    req = 4'b0100;
    stall_burst();

    for (int b = 0; b < 60; b++) begin
      req = req | N'($urandom);
      if (req == '0) req[$urandom_range(N - 1)] = 1'b1;
      mode = $urandom_range(2);
      nb = (mode == 0) ? $urandom_range(MAXB, 1) : (mode == 2) ? $urandom_range(MAXB - 1, 0) : MAXB;
      run_burst(mode, nb, 16'($urandom), ($urandom_range(3) == 0) && (mode != 2), 1'b1);
    end

    req = '0;
    repeat (4) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mealy_stream_arbiter.md
Name: mealy_stream_arbiter

Overview:
- Round-robin arbiter that shares one serial Mealy sequence detector between NUM_REQ bit-stream requesters.
- Grants one requester at a time and clears the detector before each burst.
- Steers the granted stream onto the detector input and counts detector hits per burst.
- Reports a per-burst result (owner id, hit count, abort flag) to the system controller.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of owner id; must satisfy 2**ID_W >= NUM_REQ
CNT_W, 8, width of hit counter and bit counter
MAX_BITS, 200, burst bit limit; reaching it forces end of burst
TIMEOUT, 16, idle-cycle limit inside a burst (used only with the optional feature)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester burst request; held high for the whole burst
bit_valid  in  NUM_REQ  per-requester bit strobe
bit_data  in  NUM_REQ  per-requester serial bit
bit_last  in  NUM_REQ  per-requester last-bit marker, qualified by bit_valid
gnt  out  NUM_REQ  one-hot grant, registered
det_clr  out  1  detector state clear, one cycle
det_en  out  1  detector advance enable
det_w  out  1  detector serial input
det_z  in  1  detector Mealy output, combinational from det_w and detector state
done  out  1  one-cycle result strobe
res_id  out  ID_W  owner index of the reported burst
res_hits  out  CNT_W  hits counted in the reported burst
res_abort  out  1  burst ended abnormally

Behaviour:
- Interface: one clock, Clock; reset is synchronous and active-high, Reset.
- Reset values: state=IDLE, gnt=0, det_clr=0, det_en=0, det_w=0, done=0, res_id=0, res_hits=0, res_abort=0.
- Reset internals: rr_ptr=NUM_REQ-1, hit_cnt=0, bit_cnt=0.
- Reset mid-burst discards the burst; no done pulse is issued.
- IDLE:
  - All outputs are 0 except the held res_*.
  - If any req bit is 1, go to ARB on the next edge.
- ARB, one cycle:
  - Winner = first set req bit scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Register gnt to the winner's one-hot; set rr_ptr to the winner.
  - Assert det_clr=1 for this cycle only; clear hit_cnt and bit_cnt. Next state is RUN.
  - If req has dropped to all-zero in the ARB cycle, return to IDLE with gnt=0 and no done pulse.
- RUN:
  - det_w = bit_data[owner]; det_en = bit_valid[owner]. Both are combinational from the owner's inputs.
  - On each cycle with det_en=1: bit_cnt+1, and hit_cnt+1 if det_z=1. hit_cnt saturates at 2**CNT_W-1.
  - Normal end: bit_valid & bit_last of the owner, or bit_cnt reaching MAX_BITS on this bit. Go to REPORT with res_abort=0. The ending bit is counted.
  - Abort: req[owner] drops to 0 before the last bit. Go to REPORT with res_abort=1. Bits counted so far are kept.
  - Simultaneous last bit and req drop in the same cycle counts as a normal end.
  - Non-owner bit_valid is ignored. gnt stays constant throughout RUN.
- REPORT, one cycle:
  - done=1; res_id=owner; res_hits=hit_cnt; res_abort as set above.
  - gnt=0, det_en=0.
  - res_* hold their values until the next REPORT. Next state is IDLE.
- Arbitration gap: minimum 3 cycles between the end of one burst and the first det_en of the next (REPORT, IDLE, ARB).
- Fairness: a requester that stays in req is granted at least once every NUM_REQ bursts.

Optional Feature:
- Macro: MEALY_ARB_TIMEOUT_EN.
- Defined: an idle counter runs in RUN and resets on every owner bit_valid. Reaching TIMEOUT consecutive cycles without bit_valid ends the burst via REPORT with res_abort=1.
- Not defined: no idle counter exists, and a stalled owner holds the grant indefinitely.

Test Plan:
- Reset then single requester: req=4'b0001; stream bits 0,1,1,0,1 with last on the 5th bit; detector model flags "01" (hits on bits 2 and 5). Expect ARB det_clr pulse, gnt=0001, done with res_id=0, res_hits=2, res_abort=0.
- Round-robin: req=4'b1111 held, 1-bit bursts. Expect grant order 0,1,2,3,0, with rr_ptr wrap from 3 to 0.
- Abort: owner 2 drops req after 3 bits, 1 hit. Expect done, res_id=2, res_hits=1, res_abort=1.
- MAX_BITS=8 with no bit_last. Expect done after the 8th valid bit, res_abort=0.
- Sync Reset asserted mid-RUN. Expect gnt=0 and det_en=0 on the next edge, no done pulse, and a fresh ARB starting from requester 0.
- With MEALY_ARB_TIMEOUT_EN and TIMEOUT=16: owner stalls. Expect done, res_abort=1, exactly 16 cycles after the last bit_valid. Without the macro, gnt is still held after 100 cycles.
